// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Package    : riscv_pkg
// Description: Shared core-wide constants. Source-select encodings used by
//              the request mux and the response router, and the data width.
// Revision   : 1.0 - initial release
// ============================================================================
package riscv_pkg;

    localparam int  XLEN      = 32;
    localparam logic SRC_FETCH = 1'b0;
    localparam logic SRC_LSU   = 1'b1;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/mem_resp_router_id_fifo.sv
`default_nettype none
// ============================================================================
// Module     : id_fifo
// Description: DEPTH x 1-bit in-order FIFO holding the source select of each
//              outstanding memory request.
// Ports      : clk, rst (async, active-high)
//              push/din  - write din when not full
//              pop/dout  - dout is the head entry; pop advances when not empty
//              full, empty, count - occupancy status
// Revision   : 1.0 - initial release
// ============================================================================
module id_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       din,
    output logic                       dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    import riscv_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] C_DEPTH = (PTR_W+1)'(DEPTH);

    logic [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_push;
    logic             w_pop;

    assign full  = (r_count == C_DEPTH);
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // Overflow/underflow requests are silently dropped here.
    assign w_push = push && !full;
    assign w_pop  = pop  && !empty;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: entries are only read once pushed.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= din;
    end

endmodule : id_fifo
`default_nettype wire

// File: rtl/mem_resp_router.sv
`default_nettype none
// ============================================================================
// Module     : mem_resp_router
// Description: Steers the shared memory response stream back to requester 0
//              (fetch) or 1 (load/store) in request order, through a single
//              registered output stage.
// Ports      : clk, rst            - clock, async active-high reset
//              req_fire/req_sel    - accepted request and its source (push)
//              req_ready           - ID FIFO not full
//              resp_valid/data     - memory response in
//              resp_ready          - response consumed this cycle
//              port_valid/out/ready_{0,1} - per-requester response outputs
//              outstanding         - ID FIFO occupancy
//              orphan_err          - sticky: response seen with no request
// Revision   : 1.0 - initial release
// ============================================================================
module mem_resp_router
    import riscv_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_fire,
    input  logic                   req_sel,
    output logic                   req_ready,
    input  logic                   resp_valid,
    input  logic [DATA_W-1:0]      resp_data,
    output logic                   resp_ready,
    output logic                   port_valid_0,
    output logic [DATA_W-1:0]      port_out_0,
    input  logic                   port_ready_0,
    output logic                   port_valid_1,
    output logic [DATA_W-1:0]      port_out_1,
    input  logic                   port_ready_1,
    output logic [$clog2(DEPTH):0] outstanding,
    output logic                   orphan_err
);

    logic              w_full;
    logic              w_empty;
    logic              w_head_sel;
    logic              w_drain;
    logic              w_pop;
    logic              w_owner_ready;

    logic              r_out_vld;
    logic              r_out_sel;
    logic [DATA_W-1:0] r_out_data;
    logic              r_orphan;

    id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (req_fire),
        .pop   (w_pop),
        .din   (req_sel),
        .dout  (w_head_sel),
        .full  (w_full),
        .empty (w_empty),
        .count (outstanding)
    );

    // Only the owner of the held response can release it; the other port's
    // ready is deliberately ignored so ordering is never broken.
    assign w_owner_ready = (r_out_sel == SRC_LSU) ? port_ready_1 : port_ready_0;
    assign w_drain       = r_out_vld && w_owner_ready;

    assign req_ready  = !w_full;
    assign resp_ready = !w_empty && (!r_out_vld || w_drain);
    assign w_pop      = resp_valid && resp_ready;

    assign port_valid_0 = r_out_vld && (r_out_sel == SRC_FETCH);
    assign port_valid_1 = r_out_vld && (r_out_sel == SRC_LSU);
    assign port_out_0   = port_valid_0 ? r_out_data : '0;
    assign port_out_1   = port_valid_1 ? r_out_data : '0;
    assign orphan_err   = r_orphan;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_vld  <= 1'b0;
            r_out_sel  <= 1'b0;
            r_out_data <= '0;
            r_orphan   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_out_vld  <= 1'b1;
                r_out_sel  <= w_head_sel;
                r_out_data <= resp_data;
            end else if (w_drain) begin
                r_out_vld  <= 1'b0;
            end
            if (resp_valid && w_empty) r_orphan <= 1'b1;
        end
    end

endmodule : mem_resp_router
`default_nettype wire

// File: tb/tb_mem_resp_router.sv
`default_nettype none
// ============================================================================
// Module     : tb_mem_resp_router
// Description: Directed self-checking bench for mem_resp_router
//              (DATA_W = 32, DEPTH = 4).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_mem_resp_router;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic              clk;
    logic              rst;
    logic              req_fire;
    logic              req_sel;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_data;
    logic              resp_ready;
    logic              port_valid_0;
    logic [DATA_W-1:0] port_out_0;
    logic              port_ready_0;
    logic              port_valid_1;
    logic [DATA_W-1:0] port_out_1;
    logic              port_ready_1;
    logic [2:0]        outstanding;
    logic              orphan_err;

    int n_checks;
    int n_fails;

    mem_resp_router #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .req_fire     (req_fire),
        .req_sel      (req_sel),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_data    (resp_data),
        .resp_ready   (resp_ready),
        .port_valid_0 (port_valid_0),
        .port_out_0   (port_out_0),
        .port_ready_0 (port_ready_0),
        .port_valid_1 (port_valid_1),
        .port_out_1   (port_out_1),
        .port_ready_1 (port_ready_1),
        .outstanding  (outstanding),
        .orphan_err   (orphan_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the edge so registered outputs
    // have settled and new inputs can be applied.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic s);
        req_fire = 1'b1;
        req_sel  = s;
        step();
        req_fire = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_fails      = 0;
        rst          = 1'b1;
        req_fire     = 1'b0;
        req_sel      = 1'b0;
        resp_valid   = 1'b0;
        resp_data    = '0;
        port_ready_0 = 1'b1;
        port_ready_1 = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_outstanding", 32'(outstanding), 32'd0);
        chk("rst_req_ready",   32'(req_ready),   32'd1);
        chk("rst_valid0",      32'(port_valid_0), 32'd0);
        chk("rst_valid1",      32'(port_valid_1), 32'd0);
        chk("rst_out0",        port_out_0,        32'd0);
        chk("rst_orphan",      32'(orphan_err),   32'd0);
        chk("rst_resp_ready",  32'(resp_ready),   32'd0);

        // ---------------- in-order routing ----------------
        step();
        push(1'b0); push(1'b1); push(1'b0);
        chk("io_outstanding", 32'(outstanding), 32'd3);
        resp_valid = 1'b1;
        resp_data  = 32'h0000_1111;
        #1 chk("io_resp_ready", 32'(resp_ready), 32'd1);
        step();
        chk("io_v0_a", 32'(port_valid_0), 32'd1);
        chk("io_d0_a", port_out_0, 32'h0000_1111);
        chk("io_v1_a", 32'(port_valid_1), 32'd0);
        resp_data = 32'h1111_0000;
        step();
        chk("io_v1_b", 32'(port_valid_1), 32'd1);
        chk("io_d1_b", port_out_1, 32'h1111_0000);
        chk("io_v0_b", 32'(port_valid_0), 32'd0);
        chk("io_d0_b", port_out_0, 32'd0);
        resp_data = 32'h1100_1111;
        step();
        chk("io_v0_c", 32'(port_valid_0), 32'd1);
        chk("io_d0_c", port_out_0, 32'h1100_1111);
        resp_valid = 1'b0;
        step();
        chk("io_drained", 32'(port_valid_0), 32'd0);
        chk("io_empty",   32'(outstanding), 32'd0);

        // ---------------- full ----------------
        push(1'b1); push(1'b0); push(1'b0); push(1'b0);
        chk("full_outstanding", 32'(outstanding), 32'd4);
        chk("full_req_ready",   32'(req_ready),   32'd0);
        push(1'b1);
        chk("full_5th_ignored", 32'(outstanding), 32'd4);
        resp_valid = 1'b1;
        resp_data  = 32'hAAAA_0001;
        step();
        resp_valid = 1'b0;
        chk("full_pop_out",   32'(outstanding), 32'd3);
        chk("full_pop_ready", 32'(req_ready),   32'd1);
        chk("full_pop_v1",    32'(port_valid_1), 32'd1);
        chk("full_pop_d1",    port_out_1, 32'hAAAA_0001);
        for (int i = 0; i < 3; i++) begin
            resp_valid = 1'b1;
            resp_data  = 32'hBBBB_0000 + 32'(i);
            step();
            chk("full_rest_v0", 32'(port_valid_0), 32'd1);
            chk("full_rest_d0", port_out_0, 32'hBBBB_0000 + 32'(i));
        end
        resp_valid = 1'b0;
        step();
        chk("full_drained_out", 32'(outstanding), 32'd0);

        // ---------------- backpressure ----------------
        push(1'b1); push(1'b0);
        port_ready_1 = 1'b0;
        resp_valid   = 1'b1;
        resp_data    = 32'hF1F1_F1F1;
        step();
        resp_data = 32'hF2F2_F2F2;
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_ready", 32'(resp_ready), 32'd0);
            step();
            chk("bp_v1", 32'(port_valid_1), 32'd1);
            chk("bp_d1", port_out_1, 32'hF1F1_F1F1);
            chk("bp_v0", 32'(port_valid_0), 32'd0);
        end
        chk("bp_outstanding", 32'(outstanding), 32'd1);
        port_ready_1 = 1'b1;
        #1 chk("bp_release_ready", 32'(resp_ready), 32'd1);
        step();
        resp_valid = 1'b0;
        chk("bp_after_v0", 32'(port_valid_0), 32'd1);
        chk("bp_after_d0", port_out_0, 32'hF2F2_F2F2);
        chk("bp_after_v1", 32'(port_valid_1), 32'd0);
        step();

        // ---------------- simultaneous push and pop ----------------
        push(1'b0); push(1'b1);
        chk("sim_pre", 32'(outstanding), 32'd2);
        req_fire   = 1'b1;
        req_sel    = 1'b0;
        resp_valid = 1'b1;
        resp_data  = 32'h6666_0001;
        step();
        req_fire = 1'b0;
        chk("sim_count", 32'(outstanding), 32'd2);
        chk("sim_v0_a", 32'(port_valid_0), 32'd1);
        chk("sim_d0_a", port_out_0, 32'h6666_0001);
        resp_data = 32'h6666_0002;
        step();
        chk("sim_v1_b", 32'(port_valid_1), 32'd1);
        chk("sim_d1_b", port_out_1, 32'h6666_0002);
        resp_data = 32'h6666_0003;
        step();
        chk("sim_v0_c", 32'(port_valid_0), 32'd1);
        chk("sim_d0_c", port_out_0, 32'h6666_0003);
        resp_valid = 1'b0;
        step();
        chk("sim_empty", 32'(outstanding), 32'd0);

        // ---------------- orphan ----------------
        chk("orph_pre", 32'(orphan_err), 32'd0);
        resp_valid = 1'b1;
        resp_data  = 32'hDEAD_BEEF;
        #1 chk("orph_resp_ready", 32'(resp_ready), 32'd0);
        step();
        resp_valid = 1'b0;
        chk("orph_set", 32'(orphan_err), 32'd1);
        chk("orph_no_v0", 32'(port_valid_0), 32'd0);
        push(1'b1);
        resp_valid = 1'b1;
        resp_data  = 32'h1234_5678;
        step();
        resp_valid = 1'b0;
        chk("orph_norm_v1", 32'(port_valid_1), 32'd1);
        chk("orph_norm_d1", port_out_1, 32'h1234_5678);
        chk("orph_sticky", 32'(orphan_err), 32'd1);
        step();

        // ---------------- reset mid-traffic ----------------
        push(1'b1); push(1'b0); push(1'b1);
        port_ready_1 = 1'b0;
        resp_valid   = 1'b1;
        resp_data    = 32'h7777_7777;
        step();
        chk("mr_pre_v1", 32'(port_valid_1), 32'd1);
        rst = 1'b1;
        #1 chk("mr_async_v1", 32'(port_valid_1), 32'd0);
        step();
        step();
        rst          = 1'b0;
        resp_valid   = 1'b0;
        port_ready_1 = 1'b1;
        #1;
        chk("mr_outstanding", 32'(outstanding), 32'd0);
        chk("mr_req_ready",   32'(req_ready),   32'd1);
        chk("mr_v0",          32'(port_valid_0), 32'd0);
        chk("mr_v1",          32'(port_valid_1), 32'd0);
        chk("mr_orphan",      32'(orphan_err),   32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_mem_resp_router
`default_nettype wire
